// File: rtl/gpio_csr_pkg.sv
// Shared definitions for the GPIO/CSR slave:
// register offsets, bank stride, byte-enable helper.
package gpio_csr_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t OFS_OUT    = 3'd0;
  localparam reg_idx_t OFS_IN     = 3'd1;
  localparam reg_idx_t OFS_SET    = 3'd2;
  localparam reg_idx_t OFS_CLR    = 3'd3;
  localparam reg_idx_t OFS_IRQ_EN = 3'd4;
  localparam reg_idx_t OFS_RISE   = 3'd5;
  localparam reg_idx_t OFS_FALL   = 3'd6;
  localparam reg_idx_t OFS_STATUS = 3'd7;

  localparam int unsigned BANK_STRIDE = 32;

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_csr_slave_if.sv
// Split-transaction xif bus bundle between
// a master and the GPIO/CSR slave.
interface gpio_csr_slave_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, resp, rdata
  );
endinterface

// File: rtl/gpio_in_sync.sv
// One bank of pin synchronisers plus a delay
// flop for rising/falling edge detection.
module gpio_in_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0] dly_q, dly_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], pin_i};
    dly_d   = chain_q[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      chain_q <= '0;
      dly_q   <= '0;
    end else begin
      chain_q <= chain_d;
      dly_q   <= dly_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~dly_q;
  assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/gpio_csr_slave.sv
// Memory-mapped GPIO/CSR slave: banked outputs,
// synchronised inputs, set/clear, edge interrupts.
module gpio_csr_slave
  import gpio_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_BANKS   = 1,
  parameter int          GPIO_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  input  logic [NUM_BANKS*GPIO_WIDTH-1:0] gpio_bi,
  output logic [NUM_BANKS*GPIO_WIDTH-1:0] gpio_bo,
  output logic        irq_o
);

  typedef logic [NUM_BANKS-1:0][GPIO_WIDTH-1:0] bank_arr_t;

  logic [31:0] offs;
  logic        in_win;
  logic [2:0]  bank;
  reg_idx_t    idx;
  logic [31:0] bem_full;
  logic [GPIO_WIDTH-1:0] bem, wd, rd_sel;
  logic        unused_bits;

  bank_arr_t out_q, out_d;
  bank_arr_t ien_q, ien_d;
  bank_arr_t ren_q, ren_d;
  bank_arr_t fen_q, fen_d;
  bank_arr_t sts_q, sts_d;
  bank_arr_t sync_in, rise_ev, fall_ev;

  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  // Offset arithmetic wraps below base, so one compare bounds both ends.
  assign offs      = bus_addr_bi - BASE_ADDR;
  assign in_win    = offs < 32'(NUM_BANKS * BANK_STRIDE);
  assign bank      = offs[7:5];
  assign idx       = offs[4:2];
  assign bus_ack_o = bus_req_i & in_win;

  assign bem_full = be_mask(bus_be_bi);
  assign bem      = bem_full[GPIO_WIDTH-1:0];
  assign wd       = bus_wdata_bi[GPIO_WIDTH-1:0];
  assign unused_bits = ^{offs[31:8], offs[1:0],
                         bus_wdata_bi, bem_full};

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    gpio_in_sync #(
      .WIDTH  (GPIO_WIDTH),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .pin_i    (gpio_bi[g*GPIO_WIDTH +: GPIO_WIDTH]),
      .sync_o   (sync_in[g]),
      .rise_o   (rise_ev[g]),
      .fall_o   (fall_ev[g])
    );
  end

  always_comb begin
    out_d  = out_q;
    ien_d  = ien_q;
    ren_d  = ren_q;
    fen_d  = fen_q;
    sts_d  = sts_q;
    rd_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus_ack_o && bus_we_i && bank == 3'(b)) begin
        unique case (idx)
          OFS_OUT:    out_d[b] = (out_q[b] & ~bem) | (wd & bem);
          OFS_SET:    out_d[b] = out_q[b] | wd;
          OFS_CLR:    out_d[b] = out_q[b] & ~wd;
          OFS_IRQ_EN: ien_d[b] = wd;
          OFS_RISE:   ren_d[b] = wd;
          OFS_FALL:   fen_d[b] = wd;
          OFS_STATUS: sts_d[b] = sts_q[b] & ~wd;
          default:    ;
        endcase
      end
      // Hardware set is applied after W1C so a coincident edge wins.
      sts_d[b] = sts_d[b]
               | (rise_ev[b] & ren_q[b])
               | (fall_ev[b] & fen_q[b]);
      if (bank == 3'(b)) begin
        unique case (idx)
          OFS_OUT:    rd_sel = out_q[b];
          OFS_IN:     rd_sel = sync_in[b];
          OFS_IRQ_EN: rd_sel = ien_q[b];
          OFS_RISE:   rd_sel = ren_q[b];
          OFS_FALL:   rd_sel = fen_q[b];
          OFS_STATUS: rd_sel = sts_q[b];
          default:    rd_sel = '0;
        endcase
      end
    end
    resp_d  = bus_ack_o & ~bus_we_i;
    rdata_d = resp_d ? 32'(rd_sel) : '0;
    irq_d   = |(sts_q & ien_q);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_q   <= '0;
      ien_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      sts_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      ien_q   <= ien_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      sts_q   <= sts_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio_bo      = out_q;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign irq_o        = irq_q;

endmodule
